// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON registers on the MEM-stage data bus,
// level interrupt on tx_done/rx_valid, baud derived from a clock divider.
module uart_mmio #(
  parameter int unsigned BAUD_DIV  = 5208,
  parameter logic [31:0] ADDR_BASE = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout,
  input  logic        PC_Uart_rxd,
  output logic        PC_Uart_txd
);

  localparam logic [31:0] ADDR_TXD  = ADDR_BASE;
  localparam logic [31:0] ADDR_RXD  = ADDR_BASE + 32'd4;
  localparam logic [31:0] ADDR_CON  = ADDR_BASE + 32'd8;
  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'((BAUD_DIV / 2) - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t   tx_state_r, tx_state_s;
  logic [15:0] tx_cnt_r, tx_cnt_s;
  logic [2:0]  tx_idx_r, tx_idx_s;
  logic [7:0]  tx_data_r, tx_data_s;
  logic        txd_r, txd_s;
  logic        tx_done_r, tx_done_s, tx_done_set_s;

  rx_state_t   rx_state_r, rx_state_s;
  logic [15:0] rx_cnt_r, rx_cnt_s;
  logic [2:0]  rx_idx_r, rx_idx_s;
  logic [7:0]  rx_shift_r, rx_shift_s;
  logic [7:0]  rx_data_r, rx_data_s;
  logic [1:0]  rx_sync_r;
  logic        rx_bit_s;
  logic        good_stop_s, bad_stop_s;

  logic        rx_valid_r, rx_valid_s;
  logic        overrun_r, overrun_s;
  logic        frame_err_r, frame_err_s;
  logic        tx_ie_r, tx_ie_s;
  logic        rx_ie_r, rx_ie_s;
  logic        irq_r, irq_s;

  logic        txd_sel_s, rxd_sel_s, con_sel_s;
  logic        tx_wr_s, rxd_rd_s, con_rd_s, con_wr_s;
  logic        tx_busy_s;
  logic        unused_s;

  assign txd_sel_s = (addr == ADDR_TXD);
  assign rxd_sel_s = (addr == ADDR_RXD);
  assign con_sel_s = (addr == ADDR_CON);
  assign tx_wr_s   = wr & txd_sel_s;
  assign rxd_rd_s  = rd & rxd_sel_s;
  assign con_rd_s  = rd & con_sel_s;
  assign con_wr_s  = wr & con_sel_s;
  assign tx_busy_s = (tx_state_r != TX_IDLE);
  assign rx_bit_s  = rx_sync_r[1];
  assign unused_s  = ^wdata[31:8];

  // TX frame sequencer: next state, bit counter and serial level
  always_comb begin
    tx_state_s    = tx_state_r;
    tx_cnt_s      = tx_cnt_r;
    tx_idx_s      = tx_idx_r;
    tx_data_s     = tx_data_r;
    txd_s         = txd_r;
    tx_done_set_s = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        tx_cnt_s = 16'd0;
        if (tx_wr_s) begin
          tx_state_s = TX_START;
          tx_data_s  = wdata[7:0];
          txd_s      = 1'b0;
        end else begin
          txd_s = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s   = 16'd0;
          tx_idx_s   = 3'd0;
          tx_state_s = TX_DATA;
          txd_s      = tx_data_r[0];
        end else begin
          tx_cnt_s = tx_cnt_r + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s = 16'd0;
          if (tx_idx_r == 3'd7) begin
            tx_state_s = TX_STOP;
            txd_s      = 1'b1;
          end else begin
            tx_idx_s = tx_idx_r + 3'd1;
            txd_s    = tx_data_r[tx_idx_r + 3'd1];
          end
        end else begin
          tx_cnt_s = tx_cnt_r + 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s      = 16'd0;
          tx_state_s    = TX_IDLE;
          tx_done_set_s = 1'b1;
        end else begin
          tx_cnt_s = tx_cnt_r + 16'd1;
        end
      end
      default: begin
        tx_state_s = TX_IDLE;
        tx_cnt_s   = 16'd0;
        txd_s      = 1'b1;
      end
    endcase
  end

  // RX frame sequencer: start validation at mid-bit, then one sample per bit
  always_comb begin
    rx_state_s  = rx_state_r;
    rx_cnt_s    = rx_cnt_r;
    rx_idx_s    = rx_idx_r;
    rx_shift_s  = rx_shift_r;
    good_stop_s = 1'b0;
    bad_stop_s  = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_s = 16'd0;
        if (!rx_bit_s) begin
          rx_state_s = RX_START;
        end else begin
          rx_state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_r == HALF_LAST) begin
          rx_cnt_s = 16'd0;
          rx_idx_s = 3'd0;
          if (rx_bit_s) begin
            rx_state_s = RX_IDLE;
          end else begin
            rx_state_s = RX_DATA;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = 16'd0;
          rx_shift_s = {rx_bit_s, rx_shift_r[7:1]};
          if (rx_idx_r == 3'd7) begin
            rx_state_s = RX_STOP;
          end else begin
            rx_idx_s = rx_idx_r + 3'd1;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = 16'd0;
          rx_state_s = RX_IDLE;
          if (rx_bit_s) begin
            good_stop_s = 1'b1;
          end else begin
            bad_stop_s = 1'b1;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + 16'd1;
        end
      end
      default: begin
        rx_state_s = RX_IDLE;
        rx_cnt_s   = 16'd0;
      end
    endcase
  end

  // Status flags: a setting event wins over a same-edge read clear
  always_comb begin
    if (tx_done_set_s) begin
      tx_done_s = 1'b1;
    end else if (con_rd_s) begin
      tx_done_s = 1'b0;
    end else begin
      tx_done_s = tx_done_r;
    end

    if (good_stop_s) begin
      rx_valid_s = 1'b1;
      rx_data_s  = rx_shift_r;
    end else if (rxd_rd_s) begin
      rx_valid_s = 1'b0;
      rx_data_s  = rx_data_r;
    end else begin
      rx_valid_s = rx_valid_r;
      rx_data_s  = rx_data_r;
    end

    if (good_stop_s && rx_valid_r && !rxd_rd_s) begin
      overrun_s = 1'b1;
    end else if (con_rd_s) begin
      overrun_s = 1'b0;
    end else begin
      overrun_s = overrun_r;
    end

    if (bad_stop_s) begin
      frame_err_s = 1'b1;
    end else if (con_rd_s) begin
      frame_err_s = 1'b0;
    end else begin
      frame_err_s = frame_err_r;
    end

    if (con_wr_s) begin
      tx_ie_s = wdata[0];
      rx_ie_s = wdata[1];
    end else begin
      tx_ie_s = tx_ie_r;
      rx_ie_s = rx_ie_r;
    end

    irq_s = (tx_ie_s & tx_done_s) | (rx_ie_s & rx_valid_s);
  end

  // State register for both sequencers, flags, synchronizer and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_r  <= TX_IDLE;
      tx_cnt_r    <= 16'd0;
      tx_idx_r    <= 3'd0;
      tx_data_r   <= 8'd0;
      txd_r       <= 1'b1;
      tx_done_r   <= 1'b0;
      rx_state_r  <= RX_IDLE;
      rx_cnt_r    <= 16'd0;
      rx_idx_r    <= 3'd0;
      rx_shift_r  <= 8'd0;
      rx_data_r   <= 8'd0;
      rx_sync_r   <= 2'b11;
      rx_valid_r  <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
      tx_ie_r     <= 1'b0;
      rx_ie_r     <= 1'b0;
      irq_r       <= 1'b0;
    end else begin
      tx_state_r  <= tx_state_s;
      tx_cnt_r    <= tx_cnt_s;
      tx_idx_r    <= tx_idx_s;
      tx_data_r   <= tx_data_s;
      txd_r       <= txd_s;
      tx_done_r   <= tx_done_s;
      rx_state_r  <= rx_state_s;
      rx_cnt_r    <= rx_cnt_s;
      rx_idx_r    <= rx_idx_s;
      rx_shift_r  <= rx_shift_s;
      rx_data_r   <= rx_data_s;
      rx_sync_r   <= {rx_sync_r[0], PC_Uart_rxd};
      rx_valid_r  <= rx_valid_s;
      overrun_r   <= overrun_s;
      frame_err_r <= frame_err_s;
      tx_ie_r     <= tx_ie_s;
      rx_ie_r     <= rx_ie_s;
      irq_r       <= irq_s;
    end
  end

  // Combinational read mux; zero when not reading or address unmatched
  always_comb begin
    rdata = 32'd0;
    if (rd) begin
      if (txd_sel_s) begin
        rdata = {24'd0, tx_data_r};
      end else if (rxd_sel_s) begin
        rdata = {24'd0, rx_data_r};
      end else if (con_sel_s) begin
        rdata = {25'd0, frame_err_r, overrun_r, tx_busy_s, rx_valid_r,
                 tx_done_r, rx_ie_r, tx_ie_r};
      end else begin
        rdata = 32'd0;
      end
    end else begin
      rdata = 32'd0;
    end
  end

  assign PC_Uart_txd = txd_r;
  assign irqout      = irq_r;

endmodule
